// File: rtl/bbox_scan_traverser.sv
// Triangle bounding-box generator with screen clamping and a row-major pixel walker.
// One triangle per handshake; pixels stream out over valid/ready, done pulses at the end.
module bbox_scan_traverser #(
   parameter int COORD_W = 16,
   parameter int FRAC_W  = 8,
   parameter int RES_W   = 12
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [RES_W-1:0]                  resx,
   input  logic [RES_W-1:0]                  resy,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic signed [COORD_W+FRAC_W-1:0]  pa_x,
   input  logic signed [COORD_W+FRAC_W-1:0]  pa_y,
   input  logic signed [COORD_W+FRAC_W-1:0]  pb_x,
   input  logic signed [COORD_W+FRAC_W-1:0]  pb_y,
   input  logic signed [COORD_W+FRAC_W-1:0]  pc_x,
   input  logic signed [COORD_W+FRAC_W-1:0]  pc_y,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [RES_W-1:0]                  out_x,
   output logic [RES_W-1:0]                  out_y,
   output logic                              out_last,
   output logic [RES_W-1:0]                  bb_left,
   output logic [RES_W-1:0]                  bb_right,
   output logic [RES_W-1:0]                  bb_top,
   output logic [RES_W-1:0]                  bb_bottom,
   output logic                              bb_empty,
   output logic                              done
);

   localparam int CW = COORD_W + FRAC_W;
   localparam int EW = COORD_W + 1;

   typedef logic signed [CW-1:0] coord_t;
   typedef logic signed [EW-1:0] int_t;
   typedef logic [RES_W-1:0]     pix_t;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_SCAN} state_t;

   localparam logic signed [CW:0] RND  = {{(CW+1-FRAC_W){1'b0}}, {FRAC_W{1'b1}}};
   localparam int_t               ZERO = '0;
   localparam int_t               ONE  = int_t'(1);

   function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
      coord_t m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
      coord_t m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   function automatic int_t floor_int(input coord_t v);
      return {v[CW-1], v[CW-1:FRAC_W]};
   endfunction

   // Widened by one bit so the rounding add cannot wrap near the positive limit.
   function automatic int_t ceil_int(input coord_t v);
      logic signed [CW:0] s;
      s = {v[CW-1], v} + RND;
      return s[CW:FRAC_W];
   endfunction

   function automatic int_t res_ext(input pix_t r);
      return {{(EW-RES_W){1'b0}}, r};
   endfunction

   function automatic logic axis_empty(input int_t lo, input int_t hi, input int_t res);
      return (hi < ZERO) || (lo > (res - ONE)) || (res == ZERO);
   endfunction

   function automatic pix_t clamp_lo(input int_t lo);
      return (lo < ZERO) ? '0 : lo[RES_W-1:0];
   endfunction

   function automatic pix_t clamp_hi(input int_t hi, input int_t res);
      int_t lim;
      lim = res - ONE;
      return (hi > lim) ? lim[RES_W-1:0] : hi[RES_W-1:0];
   endfunction

   state_t r_state, w_state_nxt;
   coord_t r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
   pix_t   r_resx, r_resy;
   pix_t   r_x, r_y, r_left, r_right, r_top, r_bottom;
   logic   r_empty;

   int_t   w_xlo, w_xhi, w_ylo, w_yhi, w_rxe, w_rye;
   logic   w_empty, w_fire_in, w_fire_out, w_at_right, w_at_bottom, w_last;

   assign w_xlo = floor_int(min3(r_ax, r_bx, r_cx));
   assign w_xhi = ceil_int(max3(r_ax, r_bx, r_cx));
   assign w_ylo = floor_int(min3(r_ay, r_by, r_cy));
   assign w_yhi = ceil_int(max3(r_ay, r_by, r_cy));
   assign w_rxe = res_ext(r_resx);
   assign w_rye = res_ext(r_resy);
   assign w_empty = axis_empty(w_xlo, w_xhi, w_rxe) || axis_empty(w_ylo, w_yhi, w_rye);

   assign w_fire_in   = in_valid && in_ready;
   assign w_fire_out  = out_valid && out_ready;
   assign w_at_right  = (r_x == r_right);
   assign w_at_bottom = (r_y == r_bottom);
   assign w_last      = w_at_right && w_at_bottom;

   assign out_x     = r_x;
   assign out_y     = r_y;
   assign out_last  = (r_state == S_SCAN) && w_last;
   assign bb_left   = r_left;
   assign bb_right  = r_right;
   assign bb_top    = r_top;
   assign bb_bottom = r_bottom;
   assign bb_empty  = r_empty;

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = !rst;
            if (in_valid && !rst) w_state_nxt = S_CALC;
         end
         S_CALC: begin
            if (w_empty) begin
               done        = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            out_valid = 1'b1;
            if (out_ready && w_last) begin
               done        = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Triangle capture: data only, qualified by the handshake.
   always_ff @(posedge clk) begin
      if (w_fire_in) begin
         r_ax   <= pa_x;
         r_ay   <= pa_y;
         r_bx   <= pb_x;
         r_by   <= pb_y;
         r_cx   <= pc_x;
         r_cy   <= pc_y;
         r_resx <= resx;
         r_resy <= resy;
      end
   end

   // Box registration at the end of CALC, then the row-major walk.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x      <= '0;
         r_y      <= '0;
         r_left   <= '0;
         r_right  <= '0;
         r_top    <= '0;
         r_bottom <= '0;
         r_empty  <= 1'b0;
      end else if (r_state == S_CALC) begin
         r_empty  <= w_empty;
         r_left   <= clamp_lo(w_xlo);
         r_right  <= clamp_hi(w_xhi, w_rxe);
         r_top    <= clamp_lo(w_ylo);
         r_bottom <= clamp_hi(w_yhi, w_rye);
         r_x      <= clamp_lo(w_xlo);
         r_y      <= clamp_lo(w_ylo);
      end else if (r_state == S_SCAN && w_fire_out && !w_last) begin
         if (!w_at_right) begin
            r_x <= r_x + 1'b1;
         end else begin
            r_x <= r_left;
            r_y <= r_y + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bbox_scan_traverser.sv
// Directed bench for bbox_scan_traverser: box math, clamping, traversal order,
// backpressure, empty boxes and reset during a scan.
module tb_bbox_scan_traverser;

   localparam int CW = 24;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [11:0]          resx, resy;
   logic                 in_valid, in_ready;
   logic signed [CW-1:0] pa_x, pa_y, pb_x, pb_y, pc_x, pc_y;
   logic                 out_valid, out_ready, out_last, bb_empty, done;
   logic [11:0]          out_x, out_y, bb_left, bb_right, bb_top, bb_bottom;

   int checks = 0;
   int errors = 0;

   bbox_scan_traverser #(.COORD_W(16), .FRAC_W(8), .RES_W(12)) dut (
      .clk(clk), .rst(rst), .resx(resx), .resy(resy),
      .in_valid(in_valid), .in_ready(in_ready),
      .pa_x(pa_x), .pa_y(pa_y), .pb_x(pb_x), .pb_y(pb_y), .pc_x(pc_x), .pc_y(pc_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_last(out_last),
      .bb_left(bb_left), .bb_right(bb_right), .bb_top(bb_top), .bb_bottom(bb_bottom),
      .bb_empty(bb_empty), .done(done)
   );

   always #5 clk = ~clk;

   // Presents one triangle and returns 1 time unit after the accepting edge.
   task automatic send(input int ax, input int ay, input int bx, input int by,
                       input int cx, input int cy, input int rx, input int ry);
      int g;
      g = 0;
      while (!in_ready && g < 20) begin
         @(posedge clk); #1;
         g++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready: in_ready=%0b expected 1", in_ready);
      end
      pa_x = ax[CW-1:0]; pa_y = ay[CW-1:0];
      pb_x = bx[CW-1:0]; pb_y = by[CW-1:0];
      pc_x = cx[CW-1:0]; pc_y = cy[CW-1:0];
      resx = rx[11:0];   resy = ry[11:0];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      pa_x = '0; pa_y = '0; pb_x = '0; pb_y = '0; pc_x = '0; pc_y = '0;
      resx = 12'd1; resy = 12'd1;
   endtask

   // Called right after send(): one CALC cycle, then the first pixel with the box.
   task automatic check_box(input string nm, input int l, input int r, input int t, input int b);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s calc_cycle: out_valid=%0b in_ready=%0b expected 0 0", nm, out_valid, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s latency: out_valid=%0b expected 1", nm, out_valid);
      end
      checks++;
      if (bb_left !== l[11:0] || bb_right !== r[11:0] || bb_top !== t[11:0] ||
          bb_bottom !== b[11:0] || bb_empty !== 1'b0) begin
         errors++;
         $display("FAIL %s box: got L%0d R%0d T%0d B%0d E%0b expected L%0d R%0d T%0d B%0d E0",
                  nm, bb_left, bb_right, bb_top, bb_bottom, bb_empty, l, r, t, b);
      end
   endtask

   // Walks the expected box beat by beat against the DUT stream.
   task automatic run_scan(input string nm, input int l, input int r, input int t, input int b,
                           input int stall_beat, input int stall_len, input int abort_beat);
      int ex, ey, beats, guard, expb;
      bit fin, lst;
      ex = l; ey = t; beats = 0; guard = 0; fin = 0;
      while (!fin && guard < 5000) begin
         guard++;
         lst = (ex == r && ey == b);
         checks++;
         if (out_valid !== 1'b1 || out_x !== ex[11:0] || out_y !== ey[11:0] ||
             out_last !== lst || done !== lst) begin
            errors++;
            $display("FAIL %s beat%0d: got v%0b (%0d,%0d) last%0b done%0b expected v1 (%0d,%0d) last%0b done%0b",
                     nm, beats + 1, out_valid, out_x, out_y, out_last, done, ex, ey, lst, lst);
            if (out_valid !== 1'b1) fin = 1;
         end
         if (!fin && beats + 1 == stall_beat) begin
            out_ready = 1'b0;
            repeat (stall_len) begin
               @(posedge clk); #1;
               checks++;
               if (out_valid !== 1'b1 || out_x !== ex[11:0] || out_y !== ey[11:0] ||
                   out_last !== lst || done !== 1'b0) begin
                  errors++;
                  $display("FAIL %s stall: got v%0b (%0d,%0d) last%0b done%0b expected v1 (%0d,%0d) last%0b done0",
                           nm, out_valid, out_x, out_y, out_last, done, ex, ey, lst);
               end
            end
            out_ready = 1'b1;
            #1;
         end
         if (!fin) begin
            beats++;
            if (beats == abort_beat) begin
               rst = 1'b1;
               @(posedge clk); #1;
               checks++;
               if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL %s abort: out_valid=%0b done=%0b in_ready=%0b expected 0 0 0",
                           nm, out_valid, done, in_ready);
               end
               rst = 1'b0;
               #1;
               checks++;
               if (in_ready !== 1'b1) begin
                  errors++;
                  $display("FAIL %s abort_ready: in_ready=%0b expected 1", nm, in_ready);
               end
               fin = 1;
            end else begin
               if (lst) fin = 1;
               else if (ex < r) ex++;
               else begin ex = l; ey++; end
               @(posedge clk); #1;
               if (lst) begin
                  checks++;
                  if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
                     errors++;
                     $display("FAIL %s end: out_valid=%0b done=%0b in_ready=%0b last=%0b expected 0 0 1 0",
                              nm, out_valid, done, in_ready, out_last);
                  end
               end
            end
         end
      end
      expb = (abort_beat > 0) ? abort_beat : (r - l + 1) * (b - t + 1);
      checks++;
      if (beats !== expb) begin
         errors++;
         $display("FAIL %s beat_count: got %0d expected %0d", nm, beats, expb);
      end
   endtask

   task automatic check_empty(input string nm);
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s empty_calc: done=%0b out_valid=%0b in_ready=%0b expected 1 0 0",
                  nm, done, out_valid, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b1 || bb_empty !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s empty_after: done=%0b in_ready=%0b bb_empty=%0b out_valid=%0b expected 0 1 1 0",
                  nm, done, in_ready, bb_empty, out_valid);
      end
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s empty_idle: out_valid=%0b done=%0b expected 0 0", nm, out_valid, done);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      resx = 12'd1920; resy = 12'd1080;
      pa_x = '0; pa_y = '0; pb_x = '0; pb_y = '0; pc_x = '0; pc_y = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_last !== 1'b0 ||
          bb_empty !== 1'b0 || out_x !== 12'd0 || out_y !== 12'd0 || bb_left !== 12'd0 ||
          bb_right !== 12'd0 || bb_top !== 12'd0 || bb_bottom !== 12'd0) begin
         errors++;
         $display("FAIL reset_state: rdy%0b v%0b done%0b last%0b e%0b xy(%0d,%0d) box %0d %0d %0d %0d expected all 0",
                  in_ready, out_valid, done, out_last, bb_empty, out_x, out_y,
                  bb_left, bb_right, bb_top, bb_bottom);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: in_ready=%0b expected 1", in_ready);
      end
   endtask

   task automatic test_basic();
      send(1024, 1024, 2816, 1024, 1024, 3584, 1920, 1080);
      check_box("basic", 4, 11, 4, 14);
      run_scan("basic", 4, 11, 4, 14, 0, 0, 0);
   endtask

   task automatic test_subpixel();
      send(896, 576, 1306, 742, 1024, 768, 1920, 1080);
      check_box("subpixel", 3, 6, 2, 3);
      run_scan("subpixel", 3, 6, 2, 3, 0, 0, 0);
   endtask

   task automatic test_clamp_wrap();
      send(-1024, 1024, 506880, 1024, 1280, 279040, 1920, 1080);
      check_box("clamp", 0, 1919, 4, 1079);
      run_scan("clamp", 0, 1919, 4, 1079, 0, 0, 1921);
   endtask

   task automatic test_empty();
      send(-5120, 1280, -384, 2560, -2560, 1792, 1920, 1080);
      check_empty("offscreen");
   endtask

   task automatic test_zero_res();
      send(896, 576, 1306, 742, 1024, 768, 0, 1080);
      check_empty("zero_res");
   endtask

   task automatic test_single_pixel();
      send(1792, 2304, 1792, 2304, 1792, 2304, 1920, 1080);
      check_box("single", 7, 7, 9, 9);
      run_scan("single", 7, 7, 9, 9, 0, 0, 0);
   endtask

   task automatic test_backpressure();
      send(896, 576, 1306, 742, 1024, 768, 1920, 1080);
      check_box("stall", 3, 6, 2, 3);
      run_scan("stall", 3, 6, 2, 3, 3, 5, 0);
   endtask

   task automatic test_reset_mid_scan();
      send(1024, 1024, 2816, 1024, 1024, 3584, 1920, 1080);
      check_box("abort", 4, 11, 4, 14);
      run_scan("abort", 4, 11, 4, 14, 0, 0, 40);
      send(896, 576, 1306, 742, 1024, 768, 1920, 1080);
      check_box("after_abort", 3, 6, 2, 3);
      run_scan("after_abort", 3, 6, 2, 3, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      send(1792, 2304, 1792, 2304, 1792, 2304, 1920, 1080);
      check_box("b2b_first", 7, 7, 9, 9);
      run_scan("b2b_first", 7, 7, 9, 9, 0, 0, 0);
      send(896, 576, 1306, 742, 1024, 768, 1920, 1080);
      check_box("b2b_second", 3, 6, 2, 3);
      run_scan("b2b_second", 3, 6, 2, 3, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_subpixel();
      test_empty();
      test_subpixel();
      test_zero_res();
      test_single_pixel();
      test_clamp_wrap();
      test_backpressure();
      test_reset_mid_scan();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
